// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the execute stage (master) and
// the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: posts stores into a small FIFO store buffer drained to the
// RAM2Kx32 macro in idle port cycles, and serves loads from the buffer or the RAM.
module dmem_responder #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int SB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus,
  output logic              sb_empty,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  // RSP_RAM: response data is live on ram_q; RSP_HELD: data sits in rsp_data_q
  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_RAM,
    RSP_HELD
  } rsp_state_t;

  rsp_state_t rsp_state_q, rsp_state_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, idx;
  logic [CNT_W-1:0]  count_q;

  logic              sb_full;
  logic              rsp_valid;
  logic              req_ready;
  logic              load_acc, store_acc;
  logic              sb_hit;
  logic [DATA_W-1:0] hit_data;
  logic              rd_issue, drain;

  assign sb_full   = (count_q == CNT_W'(SB_DEPTH));
  assign sb_empty  = (count_q == '0);
  assign rsp_valid = (rsp_state_q != RSP_IDLE);

  // Requests are held off during reset so the RAM port stays quiet
  assign req_ready = rst_n && !sb_full && !(rsp_valid && !bus.rsp_ready);
  assign load_acc  = bus.req_valid && req_ready && !bus.req_we;
  assign store_acc = bus.req_valid && req_ready && bus.req_we;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = (rsp_state_q == RSP_RAM) ? ram_q : rsp_data_q;

  // Walk oldest to youngest so the youngest matching store wins
  always_comb begin
    sb_hit   = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (sb_addr[idx] == bus.req_addr)) begin
        sb_hit   = 1'b1;
        hit_data = sb_data[idx];
      end
    end
  end

  assign rd_issue = load_acc && !sb_hit;
  assign drain    = rst_n && !rd_issue && !sb_empty;

  always_comb begin
    ram_cen = 1'b1;
    ram_wen = 1'b1;
    ram_a   = '0;
    ram_d   = '0;
    if (rd_issue) begin
      ram_cen = 1'b0;
      ram_a   = bus.req_addr;
    end else if (drain) begin
      ram_cen = 1'b0;
      ram_wen = 1'b0;
      ram_a   = sb_addr[head_q];
      ram_d   = sb_data[head_q];
    end
  end

  // A stalled RAM response is captured after its first cycle, since ram_q
  // is only guaranteed for the cycle following the read
  always_comb begin
    rsp_state_d = rsp_state_q;
    rsp_data_d  = rsp_data_q;
    if (load_acc) begin
      if (sb_hit) begin
        rsp_state_d = RSP_HELD;
        rsp_data_d  = hit_data;
      end else begin
        rsp_state_d = RSP_RAM;
      end
    end else if (rsp_valid && bus.rsp_ready) begin
      rsp_state_d = RSP_IDLE;
    end else if (rsp_state_q == RSP_RAM) begin
      rsp_state_d = RSP_HELD;
      rsp_data_d  = ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_state_q <= RSP_IDLE;
      rsp_data_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      rsp_state_q <= rsp_state_d;
      rsp_data_q  <= rsp_data_d;
      if (store_acc) tail_q <= tail_q + PTR_W'(1);
      if (drain)     head_q <= head_q + PTR_W'(1);
      if (store_acc && !drain)      count_q <= count_q + CNT_W'(1);
      else if (!store_acc && drain) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (store_acc) begin
      sb_addr[tail_q] <= bus.req_addr;
      sb_data[tail_q] <= bus.req_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: RAM macro model, program-order memory reference,
// directed vector table, hand-written corner sequences and random traffic.
module tb_dmem_responder;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 32;
  localparam int SB_DEPTH = 2;
  localparam int DEPTH    = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic              sb_empty, ram_cen, ram_wen;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d, ram_q;

  dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sb_empty (sb_empty),
    .ram_cen  (ram_cen),
    .ram_wen  (ram_wen),
    .ram_a    (ram_a),
    .ram_d    (ram_d),
    .ram_q    (ram_q)
  );

  function automatic logic [31:0] init_val(input int a);
    if (a == DEPTH - 1) return 32'hDEADBEEF;
    return 32'h5A000000 ^ (32'(a) * 32'h00010003);
  endfunction

  // RAM2Kx32 macro behaviour: synchronous write, read data the following cycle
  logic              ram_load;
  logic [DATA_W-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_val(i);
    end else if (ram_cen == 1'b0) begin
      if (ram_wen == 1'b0) ram_mem[ram_a] <= ram_d;
      else                 ram_q <= ram_mem[ram_a];
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_ent_t;

  typedef struct {
    logic              v;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic              rr;
    logic              e_ready;
    logic              e_valid;
    logic [DATA_W-1:0] e_rdata;
    logic              e_empty;
  } vec_t;

  logic [DATA_W-1:0] arch [DEPTH];
  sb_ent_t           sbq[$];
  bit                rsp_pend;
  logic [DATA_W-1:0] rsp_exp;
  int                errors = 0;
  int                checks = 0;

  logic              s_ready, s_valid, s_empty, s_cen, s_wen;
  logic [DATA_W-1:0] s_rdata, s_d;
  logic [ADDR_W-1:0] s_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wd, input logic rr);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.rsp_ready = rr;
  endtask

  // Sample mid-cycle, compare against the reference, then advance it across the edge
  task automatic checkOutput();
    bit exp_ready, load_acc, store_acc, hit, rd, drn, was_reset;
    sb_ent_t e;
    @(negedge clk);
    s_ready = bus.req_ready;
    s_valid = bus.rsp_valid;
    s_rdata = bus.rsp_rdata;
    s_empty = sb_empty;
    s_cen   = ram_cen;
    s_wen   = ram_wen;
    s_a     = ram_a;
    s_d     = ram_d;

    exp_ready = rst_n && (sbq.size() < SB_DEPTH) && !(rsp_pend && !bus.rsp_ready);
    check("req_ready", 32'(s_ready), 32'(exp_ready));
    check("rsp_valid", 32'(s_valid), 32'(rsp_pend));
    if (rsp_pend) check("rsp_rdata", s_rdata, rsp_exp);
    check("sb_empty", 32'(s_empty), 32'(sbq.size() == 0));

    load_acc  = bus.req_valid && exp_ready && !bus.req_we;
    store_acc = bus.req_valid && exp_ready && bus.req_we;
    hit = 1'b0;
    foreach (sbq[i]) if (sbq[i].addr == bus.req_addr) hit = 1'b1;
    rd  = load_acc && !hit;
    drn = rst_n && !rd && (sbq.size() > 0);

    if (rd) begin
      check("ram_read_cen", 32'(s_cen), 32'd0);
      check("ram_read_wen", 32'(s_wen), 32'd1);
      check("ram_read_a", 32'(s_a), 32'(bus.req_addr));
    end else if (drn) begin
      check("ram_write_cen", 32'(s_cen), 32'd0);
      check("ram_write_wen", 32'(s_wen), 32'd0);
      check("ram_write_a", 32'(s_a), 32'(sbq[0].addr));
      check("ram_write_d", s_d, sbq[0].data);
    end else begin
      check("ram_idle_cen", 32'(s_cen), 32'd1);
    end

    was_reset = !rst_n;
    if (was_reset) begin
      sbq.delete();
      rsp_pend = 1'b0;
    end else begin
      if (load_acc) begin
        rsp_pend = 1'b1;
        rsp_exp  = arch[bus.req_addr];
      end else if (rsp_pend && bus.rsp_ready) begin
        rsp_pend = 1'b0;
      end
      if (drn) void'(sbq.pop_front());
      if (store_acc) begin
        e.addr = bus.req_addr;
        e.data = bus.req_wdata;
        sbq.push_back(e);
        arch[bus.req_addr] = bus.req_wdata;
      end
    end
    @(posedge clk);
    #1;
    // Buffered stores are lost on reset, so memory reverts to what reached RAM
    if (was_reset) for (int i = 0; i < DEPTH; i++) arch[i] = ram_mem[i];
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    int   n_bad;

    ram_load = 1'b1;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    ram_load = 1'b0;
    for (int i = 0; i < DEPTH; i++) arch[i] = init_val(i);
    sbq.delete();
    rsp_pend = 1'b0;
    rsp_exp  = '0;

    // Reset held with a live request
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, 11'h123, '0, 1'b1);
      checkOutput();
      check("reset_cen", 32'(s_cen), 32'd1);
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput();
    check("post_reset_ready", 32'(s_ready), 32'd1);
    check("post_reset_rsp_valid", 32'(s_valid), 32'd0);
    check("post_reset_rdata", s_rdata, 32'd0);
    check("post_reset_empty", 32'(s_empty), 32'd1);

    // Forwarding, then drain ordering and read-back
    vecs[0]  = '{1'b1, 1'b1, 11'h004, 32'h15, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1};
    vecs[1]  = '{1'b1, 1'b0, 11'h004, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 11'h000, 32'h0,  1'b1, 1'b1, 1'b1, 32'h15, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 11'h010, 32'hA,  1'b1, 1'b1, 1'b0, 32'h0,  1'b1};
    vecs[4]  = '{1'b1, 1'b1, 11'h011, 32'hB,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    vecs[5]  = '{1'b0, 1'b0, 11'h000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    vecs[6]  = '{1'b0, 1'b0, 11'h000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b1};
    vecs[7]  = '{1'b1, 1'b0, 11'h010, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b1};
    vecs[8]  = '{1'b1, 1'b0, 11'h011, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA,  1'b1};
    vecs[9]  = '{1'b0, 1'b0, 11'h000, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB,  1'b1};
    vecs[10] = '{1'b0, 1'b0, 11'h000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b1};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].v, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rr);
      checkOutput();
      check($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) check($sformatf("vec%0d_rdata", i), s_rdata, vecs[i].e_rdata);
      check($sformatf("vec%0d_empty", i), 32'(s_empty), 32'(vecs[i].e_empty));
    end

    // Loads occupy the port so the buffered store waits, then drains on the first store cycle
    applyStimulus(1'b1, 1'b1, 11'h030, 32'h33, 1'b1);
    checkOutput();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 11'(12'h040 + k), '0, 1'b1);
      checkOutput();
      check("busy_port_wen", 32'(s_wen), 32'd1);
      check("busy_port_empty", 32'(s_empty), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 11'(12'h031 + k), 32'h100 + 32'(k), 1'b1);
      checkOutput();
      check("store_ready", 32'(s_ready), 32'd1);
      if (k == 0) begin
        check("drain_resume_wen", 32'(s_wen), 32'd0);
        check("drain_resume_a", 32'(s_a), 32'h030);
      end
    end
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput();
    end

    // Response backpressure on a RAM read
    applyStimulus(1'b1, 1'b0, 11'h7FF, '0, 1'b0);
    checkOutput();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 11'h7FE, '0, 1'b0);
      checkOutput();
      check("bp_valid", 32'(s_valid), 32'd1);
      check("bp_rdata", s_rdata, 32'hDEADBEEF);
      check("bp_ready", 32'(s_ready), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 11'h7FE, '0, 1'b1);
    checkOutput();
    check("bp_taken_rdata", s_rdata, 32'hDEADBEEF);
    check("bp_taken_ready", 32'(s_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput();
    check("bp_next_rdata", s_rdata, init_val(12'h7FE));

    // Reset while a store is still buffered
    applyStimulus(1'b1, 1'b1, 11'h020, 32'h11, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 11'h021, 32'h22, 1'b1);
    checkOutput();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput();
    check("mid_reset_no_write", 32'(s_cen), 32'd1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput();
    check("after_reset_empty", 32'(s_empty), 32'd1);
    check("after_reset_no_write", 32'(s_cen), 32'd1);
    applyStimulus(1'b1, 1'b0, 11'h021, '0, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 11'h020, '0, 1'b1);
    checkOutput();
    check("dropped_store_rdata", s_rdata, init_val(12'h021));
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput();
    check("committed_store_rdata", s_rdata, 32'h11);

    // Random traffic over a small address window to provoke buffer hits
    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                    11'(12'h200 + $urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);
      checkOutput();
    end

    repeat (10) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput();
    end
    n_bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram_mem[i] !== arch[i]) n_bad++;
    check("final_ram_mismatches", 32'(n_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
